// File: rtl/gates.sv
// Registered bitwise AND/OR/XOR/NAND/NOR of a and b, one clk of latency, a new pair every cycle.
// Reset clears outputs at once; its release is re-timed to the falling clk edge so the next rising edge already computes.
module gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5
);

  logic             rst_sync_d, rst_sync_q;
  logic [WIDTH-1:0] y1_d, y2_d, y3_d, y4_d, y5_d;
  logic [WIDTH-1:0] y1_q, y2_q, y3_q, y4_q, y5_q;

  always_comb begin
    rst_sync_d = 1'b1;
  end

  // Falling-edge capture gives release half a period to settle before the first rising edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  always_comb begin
    y1_d = a & b;
    y2_d = a | b;
    y3_d = a ^ b;
    y4_d = ~(a & b);
    y5_d = ~(a | b);
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
      y4_q <= '0;
      y5_q <= '0;
    end else begin
      y1_q <= y1_d;
      y2_q <= y2_d;
      y3_q <= y3_d;
      y4_q <= y4_d;
      y5_q <= y5_d;
    end
  end

  assign y1 = y1_q;
  assign y2 = y2_q;
  assign y3 = y3_q;
  assign y4 = y4_q;
  assign y5 = y5_q;

endmodule

// File: tb/tb_gates.sv
// Scoreboarded bench for gates at WIDTH=1 and WIDTH=4 sharing clock and reset.
module tb_gates;

  logic       clk;
  logic       rst_n;
  logic       a1, b1;
  logic [3:0] a4, b4;
  logic       y1_1, y2_1, y3_1, y4_1, y5_1;
  logic [3:0] y1_4, y2_4, y3_4, y4_4, y5_4;

  int total;
  int bad;

  logic [4:0]  q1[$];
  logic [19:0] q4[$];

  gates u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
    .y1(y1_1), .y2(y2_1), .y3(y3_1), .y4(y4_1), .y5(y5_1)
  );

  gates #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
    .y1(y1_4), .y2(y2_4), .y3(y3_4), .y4(y4_4), .y5(y5_4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Inputs change on the falling edge so each pair is held a full 20 ns period.
  task automatic drive(input logic av, input logic bv, input logic [3:0] a4v, input logic [3:0] b4v);
    @(negedge clk);
    a1 = av;
    b1 = bv;
    a4 = a4v;
    b4 = b4v;
    q1.push_back({av & bv, av | bv, av ^ bv, ~(av & bv), ~(av | bv)});
    q4.push_back({a4v & b4v, a4v | b4v, a4v ^ b4v, ~(a4v & b4v), ~(a4v | b4v)});
  endtask

  // Scoreboard: every pair pushed is checked just after the rising edge that registers it.
  always begin
    logic [4:0]  e1;
    logic [19:0] e4;
    @(posedge clk);
    #2;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      total++;
      if ({y1_1, y2_1, y3_1, y4_1, y5_1} !== e1) begin
        bad++;
        $display("FAIL sb_w1 t=%0t got=%b exp=%b", $time, {y1_1, y2_1, y3_1, y4_1, y5_1}, e1);
      end
    end
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      total++;
      if ({y1_4, y2_4, y3_4, y4_4, y5_4} !== e4) begin
        bad++;
        $display("FAIL sb_w4 t=%0t got=%h exp=%h", $time, {y1_4, y2_4, y3_4, y4_4, y5_4}, e4);
      end
    end
  end

  task automatic test_reset();
    #3;
    total++;
    if ({y1_1, y2_1, y3_1, y4_1, y5_1} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_init_w1 got=%b exp=00000", {y1_1, y2_1, y3_1, y4_1, y5_1});
    end
    total++;
    if ({y1_4, y2_4, y3_4, y4_4, y5_4} !== 20'h0) begin
      bad++;
      $display("FAIL reset_init_w4 got=%h exp=00000", {y1_4, y2_4, y3_4, y4_4, y5_4});
    end
    a1 = 1'b1; b1 = 1'b1; a4 = 4'hf; b4 = 4'hf;
    @(posedge clk);
    #2;
    total++;
    if ({y1_1, y2_1, y3_1, y4_1, y5_1} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_ones_w1 got=%b exp=00000", {y1_1, y2_1, y3_1, y4_1, y5_1});
    end
    // With zero inputs y4/y5 would go high unless reset really holds them.
    a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    @(posedge clk);
    #2;
    total++;
    if ({y1_1, y2_1, y3_1, y4_1, y5_1} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_zeros_w1 got=%b exp=00000", {y1_1, y2_1, y3_1, y4_1, y5_1});
    end
    total++;
    if ({y1_4, y2_4, y3_4, y4_4, y5_4} !== 20'h0) begin
      bad++;
      $display("FAIL reset_zeros_w4 got=%h exp=00000", {y1_4, y2_4, y3_4, y4_4, y5_4});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] ins [4];
    logic [4:0] outs [4];
    ins[0] = 2'b11; outs[0] = 5'b11000;
    ins[1] = 2'b01; outs[1] = 5'b01110;
    ins[2] = 2'b10; outs[2] = 5'b01110;
    ins[3] = 2'b00; outs[3] = 5'b00011;
    for (int i = 0; i < 4; i++) begin
      drive(ins[i][1], ins[i][0], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      @(posedge clk);
      #3;
      total++;
      if ({y1_1, y2_1, y3_1, y4_1, y5_1} !== outs[i]) begin
        bad++;
        $display("FAIL truth_a%0b_b%0b got=%b exp=%b", ins[i][1], ins[i][0],
                 {y1_1, y2_1, y3_1, y4_1, y5_1}, outs[i]);
      end
    end
  endtask

  task automatic test_width4();
    drive(1'b1, 1'b1, 4'b1100, 4'b1010);
    @(posedge clk);
    #3;
    total++;
    if ({y1_4, y2_4, y3_4, y4_4, y5_4} !== {4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001}) begin
      bad++;
      $display("FAIL width4_vec got=%b_%b_%b_%b_%b exp=1000_1110_0110_0111_0001",
               y1_4, y2_4, y3_4, y4_4, y5_4);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 4'h5, 4'h3);
    @(posedge clk);
    #3;
    a1 = 1'b0; b1 = 1'b1; a4 = 4'ha; b4 = 4'hc;
    #3;
    total++;
    if ({y1_1, y2_1, y3_1, y4_1, y5_1} !== 5'b01110) begin
      bad++;
      $display("FAIL hold_w1 got=%b exp=01110", {y1_1, y2_1, y3_1, y4_1, y5_1});
    end
    total++;
    if ({y1_4, y2_4, y3_4, y4_4, y5_4} !== {4'b0001, 4'b0111, 4'b0110, 4'b1110, 4'b1000}) begin
      bad++;
      $display("FAIL hold_w4 got=%b_%b_%b_%b_%b exp=0001_0111_0110_1110_1000",
               y1_4, y2_4, y3_4, y4_4, y5_4);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    repeat (2) @(posedge clk);
    #3;
  endtask

  task automatic test_midstream_reset();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    total++;
    if ({y1_1, y2_1, y3_1, y4_1, y5_1} !== 5'b00000) begin
      bad++;
      $display("FAIL midreset_w1 got=%b exp=00000", {y1_1, y2_1, y3_1, y4_1, y5_1});
    end
    total++;
    if ({y1_4, y2_4, y3_4, y4_4, y5_4} !== 20'h0) begin
      bad++;
      $display("FAIL midreset_w4 got=%h exp=00000", {y1_4, y2_4, y3_4, y4_4, y5_4});
    end
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    @(posedge clk);
    #3;
    total++;
    if ({y4_1, y5_1} !== 2'b11) begin
      bad++;
      $display("FAIL release_first_edge got=%b exp=11", {y4_1, y5_1});
    end
    total++;
    if ({y4_4, y5_4} !== 8'hff) begin
      bad++;
      $display("FAIL release_first_edge_w4 got=%h exp=ff", {y4_4, y5_4});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    test_reset();
    test_truth_table();
    test_width4();
    test_hold();
    test_back_to_back();
    test_midstream_reset();
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (q1.size() + q4.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d exp=0", q1.size() + q4.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gates.md
GATES -- requirements
Module: gates

Interface
REQ-001 Parameter WIDTH, default 1: bit width of operands a, b and of every output y1..y5; legal range 1..64.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port a, input, WIDTH: operand A.
REQ-005 Port b, input, WIDTH: operand B.
REQ-006 Port y1, output, WIDTH: registered AND result.
REQ-007 Port y2, output, WIDTH: registered OR result.
REQ-008 Port y3, output, WIDTH: registered XOR result.
REQ-009 Port y4, output, WIDTH: registered NAND result.
REQ-010 Port y5, output, WIDTH: registered NOR result.
REQ-011 The block SHALL have exactly one clock, clk; reset SHALL be rst_n, asynchronous assertion, active-low, with no other clock or reset inputs.

Function
REQ-012 On each rising clk edge with rst_n high, the block SHALL register y1 = a AND b, bitwise.
REQ-013 Same edge: y2 SHALL register a OR b, bitwise.
REQ-014 Same edge: y3 SHALL register a XOR b, bitwise.
REQ-015 Same edge: y4 SHALL register NOT (a AND b), bitwise.
REQ-016 Same edge: y5 SHALL register NOT (a OR b), bitwise.
REQ-017 Latency SHALL be exactly one clk cycle from a/b sampled at edge N to y1..y5 valid after edge N; no combinational path from a/b to any output.
REQ-018 Each output bit i SHALL depend only on a[i] and b[i]; no cross-bit interaction, no carries.
REQ-019 Outputs SHALL hold their value between rising edges regardless of a/b changes.
REQ-020 All five outputs SHALL update on the same edge; no output SHALL lag another.
REQ-021 a and b changing simultaneously SHALL produce results from the new pair only; no partial or mixed-pair outputs.
REQ-022 Inputs SHALL need no handshake; a new pair is accepted every cycle, sustained throughput one pair per cycle.

Reset
REQ-023 While rst_n is low, y1..y5 SHALL all be 0, including y4 and y5, independent of a, b and clk.
REQ-024 Reset assertion SHALL clear outputs immediately, without waiting for a clk edge, including mid-stream.
REQ-025 After rst_n deasserts, the first rising edge SHALL register results for the a/b present at that edge; no extra dead cycles.
REQ-026 Reset deassertion SHALL be synchronized to clk inside the block so release is glitch-free.

Verification
REQ-027 The bench SHALL cover these cases; results appear one cycle after the a/b values are applied:
- a=1, b=1 -> y1=1 y2=1 y3=0 y4=0 y5=0
- a=0, b=1 -> y1=0 y2=1 y3=1 y4=1 y5=0
- a=1, b=0 -> y1=0 y2=1 y3=1 y4=1 y5=0
- a=0, b=0 -> y1=0 y2=0 y3=0 y4=1 y5=1
- rst_n pulled low mid-stream with a=0, b=0 -> all outputs 0 immediately, before the next edge; after release plus one edge -> y4=1, y5=1
- WIDTH=4, a=4'b1100, b=4'b1010 -> y1=1000 y2=1110 y3=0110 y4=0111 y5=0001
REQ-028 Each input pair SHALL be held at least 20 ns, and the bench SHALL compare outputs against a bitwise reference model on every cycle.
